main_memory_capture_controller: RTL
===================================

MAIN_MEMORY_CAPTURE_CONTROLLER -- requirements
Module: main_memory_capture_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 14: width of the capture length and word counters.
REQ-002 Parameter TRIG_TIMEOUT, default 1000000: trigger wait limit in clock cycles, used only with the Configuration macro.
REQ-003 i_capture_ctrl_clk  input  1: single clock, the ADC write clock; all logic rising-edge.
REQ-004 i_capture_ctrl_reset  input  1: reset, asynchronous, active-high.
REQ-005 i_capture_ctrl_start  input  1: one-cycle capture request, from the SPI register block.
REQ-006 i_capture_ctrl_abort  input  1: abort the capture in progress; level-sensitive.
REQ-007 i_capture_ctrl_len  input  CNT_WIDTH: number of BRAM words to write; sampled on an accepted start.
REQ-008 i_capture_ctrl_ext_trig  input  1: raw external trigger from SMA1 J7, asynchronous.
REQ-009 i_capture_ctrl_ext_trig_en  input  1: external trigger enable; sampled on an accepted start.
REQ-010 i_capture_ctrl_fifo_full  input  1: BRAM FIFO full flag.
REQ-011 i_capture_ctrl_rd_done  input  1: one-cycle pulse meaning the readout has completed.
REQ-012 o_capture_ctrl_bram_wr_clk_en  output  1: BRAM FIFO write clock enable.
REQ-013 o_capture_ctrl_busy  output  1: high in every state except IDLE.
REQ-014 o_capture_ctrl_done  output  1: high in DONE.
REQ-015 o_capture_ctrl_overflow  output  1: sticky flag; FIFO became full during CAPTURE.
REQ-016 o_capture_ctrl_trig_timeout  output  1: sticky flag; capture was forced by the timeout.
REQ-017 o_capture_ctrl_word_cnt  output  CNT_WIDTH: number of words written in the current capture.
REQ-018 o_capture_ctrl_state  output  2: state encoding IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.

Function
REQ-019 The external trigger SHALL pass through a 2-flop synchronizer; a trigger event is a rising edge of the synchronized signal, detected against a third flop.
REQ-020 In IDLE, start with len!=0 SHALL latch len and ext_trig_en, clear word_cnt and both sticky flags, and move to WAIT_TRIG if ext_trig_en=1, else to CAPTURE.
REQ-021 Start with len=0, or start in any non-IDLE state, SHALL be ignored with no output change.
REQ-022 In WAIT_TRIG, a trigger event SHALL move the block to CAPTURE on the next edge; a raw trigger rising before edge k gives CAPTURE at edge k+3.
REQ-023 bram_wr_clk_en SHALL be registered and high exactly in the cycles where state=CAPTURE and fifo_full=0.
REQ-024 word_cnt SHALL increment by 1 on each cycle where bram_wr_clk_en=1, without wrapping.
REQ-025 When bram_wr_clk_en=1 and word_cnt=len-1, the next state SHALL be DONE, giving exactly len enable cycles.
REQ-026 fifo_full=1 in CAPTURE SHALL set overflow and move the block to DONE; no further enables are issued.
REQ-027 In DONE, rd_done SHALL move the block to IDLE; rd_done in any other state SHALL be ignored.
REQ-028 abort=1 SHALL force IDLE on the next edge from any state, overriding start, trigger and rd_done in the same cycle; word_cnt and the sticky flags hold their values.
REQ-029 If a trigger event and the final write occur together, the trigger SHALL be ignored.

Reset
REQ-030 Reset SHALL force: state IDLE; every output 0; the synchronizer flops, the counters and the latched len/ext_trig_en to 0.
REQ-031 Reset asserted mid-capture SHALL drop bram_wr_clk_en asynchronously, in the same cycle.

Configuration
REQ-032 With macro CAPTURE_CTRL_TRIG_TIMEOUT_EN defined, a counter SHALL run in WAIT_TRIG; TRIG_TIMEOUT cycles without a trigger SHALL force CAPTURE and set trig_timeout.
REQ-033 Without CAPTURE_CTRL_TRIG_TIMEOUT_EN, WAIT_TRIG SHALL wait indefinitely, and trig_timeout SHALL be tied to 0.

Verification
REQ-034 ext_trig_en=0, len=16, start pulse -> 16 consecutive enable cycles starting 1 cycle after start; word_cnt=16; done=1; rd_done -> IDLE.
REQ-035 ext_trig_en=1, len=8, trigger rising 20 cycles after start -> CAPTURE exactly 3 edges after the trigger; 8 enable cycles; done.
REQ-036 len=100, fifo_full asserted after 40 writes -> enable low from that cycle; overflow=1; DONE with word_cnt=40.
REQ-037 abort asserted on the 5th CAPTURE cycle, together with a start pulse -> IDLE next edge; enable 0; word_cnt=5; the start is ignored.
REQ-038 Start with len=0, and start in DONE -> no state change; rd_done pulse while in CAPTURE -> ignored.
REQ-039 Macro defined, TRIG_TIMEOUT=50, no trigger -> CAPTURE after 50 cycles in WAIT_TRIG; trig_timeout=1; macro undefined -> still WAIT_TRIG after 10000 cycles.

Source files
------------

// File: rtl/main_memory_capture_controller.sv
// Capture sequencer: arms on start, optionally waits for the external trigger, then streams
// len write enables into the BRAM FIFO. Trigger timeout enabled by CAPTURE_CTRL_TRIG_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for an accepted start
// WAIT_TRIG | armed, waiting for a synchronized external trigger edge
// CAPTURE   | issuing BRAM FIFO write enables
// DONE      | capture finished, waiting for readout to complete
module main_memory_capture_controller #(
    parameter int CNT_WIDTH    = 14,
    parameter int TRIG_TIMEOUT = 1000000
) (
    input  logic                 i_capture_ctrl_clk,
    input  logic                 i_capture_ctrl_reset,
    input  logic                 i_capture_ctrl_start,
    input  logic                 i_capture_ctrl_abort,
    input  logic [CNT_WIDTH-1:0] i_capture_ctrl_len,
    input  logic                 i_capture_ctrl_ext_trig,
    input  logic                 i_capture_ctrl_ext_trig_en,
    input  logic                 i_capture_ctrl_fifo_full,
    input  logic                 i_capture_ctrl_rd_done,
    output logic                 o_capture_ctrl_bram_wr_clk_en,
    output logic                 o_capture_ctrl_busy,
    output logic                 o_capture_ctrl_done,
    output logic                 o_capture_ctrl_overflow,
    output logic                 o_capture_ctrl_trig_timeout,
    output logic [CNT_WIDTH-1:0] o_capture_ctrl_word_cnt,
    output logic [1:0]           o_capture_ctrl_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   len_q;
    logic                   trig_en_q;
    logic [2:0]             trig_sync;
    logic                   trig_evt_q;
    logic                   en_q;
    logic [CNT_WIDTH-1:0]   word_cnt;
    logic                   overflow_q;
    logic                   wr_en;
    logic                   start_ok;
    logic                   last_word;
    logic                   trig_hit;
    logic                   timeout_hit;

    assign start_ok  = (state == IDLE) && i_capture_ctrl_start &&
                       (i_capture_ctrl_len != '0) && !i_capture_ctrl_abort;
    assign wr_en     = en_q & ~i_capture_ctrl_fifo_full;
    assign last_word = wr_en && (word_cnt == (len_q - CNT_ONE));
    assign trig_hit  = trig_evt_q && trig_en_q;

    // Two-flop synchronizer, third flop for edge detect; the edge is registered once more
    // so the FSM sees a clean single-cycle event.
    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            trig_sync  <= 3'b000;
            trig_evt_q <= 1'b0;
        end else begin
            trig_sync  <= {trig_sync[1:0], i_capture_ctrl_ext_trig};
            trig_evt_q <= trig_sync[1] & ~trig_sync[2];
        end
    end

`ifdef CAPTURE_CTRL_TRIG_TIMEOUT_EN
    localparam int TO_W = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TRIG_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            to_cnt <= '0;
        end else if (start_ok) begin
            to_cnt <= TO_LOAD;
        end else if ((state == WAIT_TRIG) && (to_cnt != '0)) begin
            to_cnt <= to_cnt - TO_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT_TRIG) && (to_cnt == '0);

    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            timeout_q <= 1'b0;
        end else if (start_ok) begin
            timeout_q <= 1'b0;
        end else if (!i_capture_ctrl_abort && timeout_hit && !trig_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign o_capture_ctrl_trig_timeout = timeout_q;
`else
    // Without the timeout WAIT_TRIG waits forever; TRIG_TIMEOUT has no effect.
    logic unused_trig_timeout;
    assign unused_trig_timeout         = (TRIG_TIMEOUT != 0);
    assign timeout_hit                 = 1'b0;
    assign o_capture_ctrl_trig_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = i_capture_ctrl_ext_trig_en ? WAIT_TRIG : CAPTURE;
                end
            end
            WAIT_TRIG: begin
                if (trig_hit || timeout_hit) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (i_capture_ctrl_fifo_full || last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_capture_ctrl_rd_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (i_capture_ctrl_abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            state <= IDLE;
            en_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            en_q  <= (state_nxt == CAPTURE);
        end
    end

    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            len_q     <= '0;
            trig_en_q <= 1'b0;
        end else if (start_ok) begin
            len_q     <= i_capture_ctrl_len;
            trig_en_q <= i_capture_ctrl_ext_trig_en;
        end
    end

    // Saturates rather than wraps so a runaway count is still visible to software.
    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            word_cnt <= '0;
        end else if (start_ok) begin
            word_cnt <= '0;
        end else if (wr_en && (word_cnt != CNT_MAX)) begin
            word_cnt <= word_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge i_capture_ctrl_clk or posedge i_capture_ctrl_reset) begin
        if (i_capture_ctrl_reset) begin
            overflow_q <= 1'b0;
        end else if (start_ok) begin
            overflow_q <= 1'b0;
        end else if ((state == CAPTURE) && i_capture_ctrl_fifo_full && !i_capture_ctrl_abort) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_capture_ctrl_bram_wr_clk_en = wr_en;
    assign o_capture_ctrl_busy           = (state != IDLE);
    assign o_capture_ctrl_done           = (state == DONE);
    assign o_capture_ctrl_overflow       = overflow_q;
    assign o_capture_ctrl_word_cnt       = word_cnt;
    assign o_capture_ctrl_state          = state;

endmodule
